wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- Shares one pipelined Wishbone-style slave port between NM masters.
- Its single output port feeds the address decoder, which fans out to slaves.
- Round-robin arbitration on bus-cycle requests; the grant is held for the whole master cycle.
- Counts outstanding requests and routes ack/err back to the granted master.

Parameters:
- NM, 4, number of masters (>=2)
- AW, 32, address width
- DW, 38, request payload width (data+sel+we+flags)
- LGMAXBURST, 4, log2 of maximum outstanding requests; counter is LGMAXBURST+1 bits wide

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_mcyc  in  NM  per-master bus-cycle request
- i_mvalid  in  NM  per-master request strobe
- o_mstall  out  NM  per-master stall
- i_maddr  in  NM*AW  master addresses, master k at [k*AW +: AW]
- i_mdata  in  NM*DW  master payloads, master k at [k*DW +: DW]
- o_mack  out  NM  per-master ack
- o_merr  out  NM  per-master bus error
- o_scyc  out  1  slave-side cycle
- o_svalid  out  1  slave-side request strobe
- i_sstall  in  1  slave-side stall
- o_saddr  out  AW  slave-side address
- o_sdata  out  DW  slave-side payload
- i_sack  in  1  slave-side ack
- i_serr  in  1  slave-side error
- o_grant  out  NM  one-hot current grant (debug/observability)

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, o_grant=0, rr pointer=0, outstanding=0. Hence o_scyc=0, o_svalid=0, o_mack=0, o_merr=0, o_mstall=all-ones.
- FSM IDLE:
  - If any i_mcyc is set, register a one-hot grant to the first requester at or after the pointer, wrapping from NM-1 to 0. Move to GRANTED.
  - Latency: grant visible one cycle after i_mcyc rises. No request passes in that same cycle.
- FSM GRANTED (master g):
  - o_scyc=i_mcyc[g].
  - o_svalid=i_mvalid[g] && !full.
  - o_saddr/o_sdata come combinationally from master g.
  - o_mstall[g]=i_sstall||full. All other o_mstall bits = 1.
  - full = (outstanding == 2^LGMAXBURST).
- Accept = o_svalid && !i_sstall. Outstanding counter:
  - +1 on accept.
  - -1 on i_sack or i_serr.
  - Unchanged when accept and ack occur in the same cycle.
- Ack routing:
  - o_mack[g]=i_sack. o_merr[g]=i_serr. Both combinational; other bits 0.
  - i_sack/i_serr while outstanding==0 or in IDLE: ignored, not forwarded.
- i_serr:
  - Clears outstanding to 0.
  - Grant is kept. Further acks in that cycle are suppressed to the master.
- Release: when i_mcyc[g] falls (abort or normal end):
  - Next state IDLE, outstanding cleared, pointer=g+1 mod NM.
  - Late acks are dropped.
  - No re-grant in the release cycle; earliest new grant is the following cycle.
- Fairness: a continuously requesting master cannot be re-granted while another master is waiting.
- Reset mid-cycle returns to IDLE immediately, with all outputs at their reset values.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN, with parameter LGTIMEOUT (default 10).
- Defined:
  - Watchdog counts cycles while outstanding!=0 with no i_sack/i_serr. It restarts on every ack/err.
  - On reaching 2^LGTIMEOUT-1: assert o_merr[g] for one cycle, clear outstanding, force o_scyc=0 that cycle, go to IDLE, advance pointer.
- Undefined: no watchdog; transactions may stall indefinitely.

Decomposition:
- Package wb_arb_pkg: state enum {IDLE, GRANTED} and a function computing counter width from LGMAXBURST.
- Sub-module rr_pick: combinational round-robin one-hot picker with inputs req[NM] and ptr, output gnt[NM]. Instantiated once.

Test Plan:
- Single master: m1 raises cyc, issues 3 requests, gets 3 acks, drops cyc. Grant=0010 one cycle after cyc; o_svalid on 3 accepts; o_mack[1] pulses 3x; grant returns to 0.
- Contention: m0, m2, m3 raise cyc together at pointer=0. Grants in order m0→m2→m3 across releases, each gap = 1 IDLE cycle.
- Backpressure (LGMAXBURST=2): 6 requests, no acks. Accepts stop at 4 with o_mstall[g]=1. One ack leads to exactly 1 more accept.
- Simultaneous accept+ack at outstanding=2 leaves it at 2. Error at outstanding=3 gives o_merr[g]=1 and outstanding=0.
- Abort: master drops cyc with 2 outstanding. Next-cycle i_sack not forwarded, counter=0, waiting master granted the cycle after.
- WB_ARB_TIMEOUT_EN, LGTIMEOUT=4: 1 request, no ack. o_merr[g] pulses 15 cycles after the last activity, and the FSM goes to IDLE.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// ============================================================================
// Module : wb_arb_pkg
// Brief  : Shared types and sizing helpers for the Wishbone round-robin arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  // The counter must represent 0 .. 2^lg inclusive.
  function automatic int cnt_width(input int lg);
    return lg + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational one-hot round-robin picker; first request at or after
//          the pointer wins, wrapping to the lowest index.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NM = 4,
  parameter int PW = 2
) (
  input  logic [NM-1:0] i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [NM-1:0] o_gnt
);

  logic [NM-1:0] w_mask;
  logic [NM-1:0] w_hi;
  logic [NM-1:0] w_hi_low;
  logic [NM-1:0] w_lo_low;

  // x & -x isolates the lowest set bit.
  assign w_mask   = ~((NM'(1) << i_ptr) - NM'(1));
  assign w_hi     = i_req & w_mask;
  assign w_hi_low = w_hi & (~w_hi + NM'(1));
  assign w_lo_low = i_req & (~i_req + NM'(1));
  assign o_gnt    = (|w_hi) ? w_hi_low : w_lo_low;

endmodule

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module : wb_rr_arbiter
// Brief  : Round-robin arbiter sharing one pipelined Wishbone slave port among
//          NM masters; optional watchdog enabled by WB_ARB_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NM         = 4,
  parameter int AW         = 32,
  parameter int DW         = 38,
  parameter int LGMAXBURST = 4
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int LGTIMEOUT  = 10
`endif
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [NM-1:0]    i_mcyc,
  input  logic [NM-1:0]    i_mvalid,
  output logic [NM-1:0]    o_mstall,
  input  logic [NM*AW-1:0] i_maddr,
  input  logic [NM*DW-1:0] i_mdata,
  output logic [NM-1:0]    o_mack,
  output logic [NM-1:0]    o_merr,
  output logic             o_scyc,
  output logic             o_svalid,
  input  logic             i_sstall,
  output logic [AW-1:0]    o_saddr,
  output logic [DW-1:0]    o_sdata,
  input  logic             i_sack,
  input  logic             i_serr,
  output logic [NM-1:0]    o_grant
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = cnt_width(LGMAXBURST);
  localparam logic [CW-1:0] c_MAX_OUT = {1'b1, {LGMAXBURST{1'b0}}};
  localparam logic [PW-1:0] c_LAST    = PW'(NM - 1);

  arb_state_t    r_state;
  logic [NM-1:0] r_grant;
  logic [PW-1:0] r_gidx;
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_outstanding;

  logic [NM-1:0] w_pick;
  logic [PW-1:0] w_pick_idx;
  logic [PW-1:0] w_next_ptr;
  logic          w_cyc_g;
  logic          w_full;
  logic          w_ack_ok;
  logic          w_sack;
  logic          w_serr;
  logic          w_accept;
  logic          w_timeout;

  rr_pick #(
    .NM (NM),
    .PW (PW)
  ) u_pick (
    .i_req (i_mcyc),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NM; k++) begin
      if (w_pick[k]) w_pick_idx = PW'(k);
    end
  end

  assign w_next_ptr = (r_gidx == c_LAST) ? '0 : r_gidx + 1'b1;

  assign w_cyc_g  = (r_state == GRANTED) && (|(i_mcyc & r_grant));
  assign w_full   = (r_outstanding == c_MAX_OUT);
  // Responses only count while the granted cycle is live and something is owed.
  assign w_ack_ok = w_cyc_g && (r_outstanding != '0) && !w_timeout;
  assign w_serr   = w_ack_ok && i_serr;
  assign w_sack   = w_ack_ok && i_sack && !i_serr;

  assign o_scyc   = w_cyc_g && !w_timeout;
  assign o_svalid = o_scyc && (|(i_mvalid & r_grant)) && !w_full;
  assign w_accept = o_svalid && !i_sstall;

  assign o_mstall = ~r_grant | {NM{i_sstall || w_full}};
  assign o_mack   = r_grant & {NM{w_sack}};
  assign o_merr   = r_grant & {NM{w_serr || w_timeout}};
  assign o_grant  = r_grant;

  always_comb begin
    o_saddr = '0;
    o_sdata = '0;
    for (int k = 0; k < NM; k++) begin
      if (r_grant[k]) begin
        o_saddr = i_maddr[k*AW +: AW];
        o_sdata = i_mdata[k*DW +: DW];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [LGTIMEOUT-1:0] c_TO_FIRE = {{(LGTIMEOUT-1){1'b1}}, 1'b0};
  logic [LGTIMEOUT-1:0] r_wdog;

  // Fires in the cycle the idle count would reach 2^LGTIMEOUT-1.
  assign w_timeout = w_cyc_g && (r_outstanding != '0) && !i_sack && !i_serr &&
                     (r_wdog == c_TO_FIRE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wdog <= '0;
    end else if (!w_cyc_g || w_timeout || (r_outstanding == '0) || i_sack || i_serr) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_ptr         <= '0;
      r_outstanding <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_outstanding <= '0;
          if (|i_mcyc) begin
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
            r_state <= GRANTED;
          end
        end
        GRANTED: begin
          if (!w_cyc_g || w_timeout) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_outstanding <= '0;
            r_ptr         <= w_next_ptr;
          end else if (w_serr) begin
            r_outstanding <= '0;
          end else if (w_accept && !w_sack) begin
            r_outstanding <= r_outstanding + 1'b1;
          end else if (!w_accept && w_sack) begin
            r_outstanding <= r_outstanding - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
